// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage data path: op codes, byte-enable
// patterns and op classification helpers.
package mem_pkg;

    // Memory operation codes; 9..15 are unused and behave as NONE.
    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LW   = 4'd1;
    localparam logic [3:0] MEM_OP_LH   = 4'd2;
    localparam logic [3:0] MEM_OP_LHU  = 4'd3;
    localparam logic [3:0] MEM_OP_LB   = 4'd4;
    localparam logic [3:0] MEM_OP_LBU  = 4'd5;
    localparam logic [3:0] MEM_OP_SW   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SB   = 4'd8;

    // Byte-enable patterns, bit n enables byte lane n.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEM_OP_LW) && (op <= MEM_OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEM_OP_SW) && (op <= MEM_OP_SB);
    endfunction

    // Word ops need a word-aligned address, halfword ops an even address;
    // byte ops and non-memory ops can never be misaligned.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_OP_LW, MEM_OP_SW:              mis = (off != 2'b00);
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: mis = off[0];
            default:                           mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load extractor: picks the addressed byte/halfword out of the registered
// memory word and sign- or zero-extends it to 32 bits.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [3:0]  op,
    output logic [31:0] data
);

    logic [15:0] half_val;
    logic [7:0]  byte_val;

    // Lane selection and extension by op; non-load ops yield zero.
    always_comb begin
        half_val = offset[1] ? raw[31:16] : raw[15:0];
        byte_val = raw[{offset, 3'b000} +: 8];
        data     = 32'h0;
        case (op)
            MEM_OP_LW:  data = raw;
            MEM_OP_LH:  data = {{16{half_val[15]}}, half_val};
            MEM_OP_LHU: data = {16'h0, half_val};
            MEM_OP_LB:  data = {{24{byte_val[7]}}, byte_val};
            MEM_OP_LBU: data = {24'h0, byte_val};
            default:    data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// Memory-stage data path: store lane steering and byte enables toward the
// data memory, the M/W pipeline register, misalignment detection and the
// W-stage load extraction.
module mem_align_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic [3:0]        m_mem_op,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_wdata,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       dm_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_be,
    output logic              dm_we,
    output logic              w_valid,
    output logic [31:0]       w_load_data,
    output logic              w_is_load,
    output logic              w_adel,
    output logic              w_ades,
    output logic [ADDR_W-1:0] w_badaddr
);

    logic m_load;
    logic m_store;
    logic m_mis;

    assign m_load  = is_load(m_mem_op);
    assign m_store = is_store(m_mem_op);
    assign m_mis   = is_misaligned(m_mem_op, m_addr[1:0]);

    assign dm_addr = {m_addr[ADDR_W-1:2], 2'b00};

    // Store lane replication and byte enables; a misaligned store enables nothing.
    always_comb begin
        dm_wdata = m_wdata;
        dm_be    = BE_NONE;
        case (m_mem_op)
            MEM_OP_SW: begin
                dm_be = BE_WORD;
            end
            MEM_OP_SH: begin
                dm_wdata = {2{m_wdata[15:0]}};
                dm_be    = m_addr[1] ? BE_HALF_HI : BE_HALF_LO;
            end
            MEM_OP_SB: begin
                dm_wdata = {4{m_wdata[7:0]}};
                dm_be    = BE_BYTE0 << m_addr[1:0];
            end
            default: begin
                dm_be = BE_NONE;
            end
        endcase
        if (m_mis) begin
            dm_be = BE_NONE;
        end
    end

    // Stalled or flushed instructions must not reach memory.
    assign dm_we = m_valid & m_store & ~m_mis & ~stall & ~flush;

    logic              valid_d, valid_q;
    logic [31:0]       raw_d, raw_q;
    logic [3:0]        op_d, op_q;
    logic [1:0]        off_d, off_q;
    logic              adel_d, adel_q;
    logic              ades_d, ades_q;
    logic [ADDR_W-1:0] badaddr_d, badaddr_q;

    // Next M/W contents when the register advances normally.
    always_comb begin
        valid_d   = m_valid;
        raw_d     = dm_rdata;
        op_d      = m_mem_op;
        off_d     = m_addr[1:0];
        adel_d    = m_valid & m_load & m_mis;
        ades_d    = m_valid & m_store & m_mis;
        badaddr_d = (adel_d | ades_d) ? m_addr : '0;
    end

    // M/W register: reset, then flush over stall, else capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            raw_q     <= 32'h0;
            op_q      <= MEM_OP_NONE;
            off_q     <= 2'b00;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
            badaddr_q <= '0;
        end else if (flush) begin
            // A flushed slot is a clean bubble, including the load result.
            valid_q   <= 1'b0;
            raw_q     <= 32'h0;
            op_q      <= MEM_OP_NONE;
            off_q     <= 2'b00;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
            badaddr_q <= '0;
        end else if (!stall) begin
            valid_q   <= valid_d;
            raw_q     <= raw_d;
            op_q      <= op_d;
            off_q     <= off_d;
            adel_q    <= adel_d;
            ades_q    <= ades_d;
            badaddr_q <= badaddr_d;
        end
    end

    logic [31:0] ext_data;

    load_ext u_load_ext (
        .raw    (raw_q),
        .offset (off_q),
        .op     (op_q),
        .data   (ext_data)
    );

    // W-stage outputs; a faulting load never produces data or a GRF write.
    always_comb begin
        w_valid     = valid_q;
        w_load_data = adel_q ? 32'h0 : ext_data;
        w_is_load   = valid_q & is_load(op_q) & ~adel_q;
        w_adel      = adel_q;
        w_ades      = ades_q;
        w_badaddr   = badaddr_q;
    end

endmodule
